store_buffer: RTL and testbench

Word-granular store buffer sitting between the EX/MEM pipeline register and the data memory's write port. Stores retiring from MEM are queued as (word address, data, byte enables) entries and drained in order into the data memory whenever the memory port is not claimed by a load. In-flight loads are forwarded byte-accurately from the youngest matching entries, so the pipeline never reads stale memory.

---
 rtl/stb_pkg.sv | 18 +
 rtl/stb_fwd_merge.sv | 37 +++
 rtl/store_buffer.sv | 103 ++++++++++
 tb/tb_store_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stb_pkg.sv
// rtl/stb_pkg.sv - store buffer shared types, constants and byte-mask helper
package stb_pkg;

  localparam int STB_DEPTH = 4;
  localparam int WADDR_W   = 30;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [31:0]        data;
    logic [3:0]         be;
  } stb_entry_t;

  // Expand byte enables into a 32-bit bit mask
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/stb_fwd_merge.sv
// rtl/stb_fwd_merge.sv - youngest-first per-lane load forwarding over the entry array
module stb_fwd_merge
  import stb_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  stb_entry_t         i_entries [DEPTH],
  input  logic [PTR_W-1:0]   i_head,
  input  logic [PTR_W:0]     i_count,
  input  logic               i_ld_valid,
  input  logic [WADDR_W-1:0] i_ld_waddr,
  output logic [3:0]         o_fwd_be,
  output logic [31:0]        o_fwd_data
);

  // Walk entries oldest to youngest so later matches overwrite earlier ones per lane
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    o_fwd_be   = '0;
    o_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if (i_ld_valid && ((PTR_W+1)'(i) < i_count) &&
          (i_entries[w_idx].waddr == i_ld_waddr)) begin
        for (int l = 0; l < 4; l++) begin
          if (i_entries[w_idx].be[l]) begin
            o_fwd_be[l]          = 1'b1;
            o_fwd_data[8*l +: 8] = i_entries[w_idx].data[8*l +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with load forwarding; optional STB_COALESCE_EN merges same-word stores
module store_buffer
  import stb_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [3:0]  ld_fwd_be,
  output logic [31:0] ld_fwd_data,
  input  logic        dm_busy,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [3:0]  dm_be,
  output logic        stb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  stb_entry_t       r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_drain;
  logic w_push;
  logic w_coal;
  logic w_nonempty;
  logic w_unused;

  assign w_unused   = ^{st_addr[1:0], ld_addr[1:0]};
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_drain    = w_nonempty && !dm_busy;

`ifdef STB_COALESCE_EN
  logic [PTR_W-1:0] w_tail_m1;
  assign w_tail_m1 = r_tail - 1'b1;
  // The youngest entry may absorb the store unless it is the head leaving this edge
  assign w_coal = st_valid && w_nonempty &&
                  (r_entries[w_tail_m1].waddr == st_addr[31:2]) &&
                  !(w_drain && (w_tail_m1 == r_head));
`else
  assign w_coal = 1'b0;
`endif

  assign st_ready  = !w_full || w_coal;
  assign w_push    = st_valid && st_ready && !w_coal;
  assign stb_empty = !w_nonempty;

  assign dm_we   = w_drain;
  assign dm_addr = w_nonempty ? {r_entries[r_head].waddr, 2'b00} : '0;
  assign dm_wd   = w_nonempty ? r_entries[r_head].data : '0;
  assign dm_be   = w_nonempty ? r_entries[r_head].be : '0;

  // Pointer and occupancy bookkeeping; reset discards every queued store
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_drain};
    end
  end

  // Entry payload writes; validity comes from head/count so no reset is needed here
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_entries[r_tail] <= '{waddr: st_addr[31:2], data: st_data, be: st_be};
    end
`ifdef STB_COALESCE_EN
    else if (w_coal) begin
      r_entries[w_tail_m1].data <= (r_entries[w_tail_m1].data & ~be_to_mask(st_be)) |
                                   (st_data & be_to_mask(st_be));
      r_entries[w_tail_m1].be   <= r_entries[w_tail_m1].be | st_be;
    end
`endif
  end

  stb_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
    .i_entries  (r_entries),
    .i_head     (r_head),
    .i_count    (r_count),
    .i_ld_valid (ld_valid),
    .i_ld_waddr (ld_addr[31:2]),
    .o_fwd_be   (ld_fwd_be),
    .o_fwd_data (ld_fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

  logic        Clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_fwd_be;
  logic [31:0] ld_fwd_data;
  logic        dm_busy;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic        stb_empty;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 Clk = ~Clk;

  store_buffer #(.DEPTH(4)) dut (
    .Clk(Clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_fwd_be(ld_fwd_be), .ld_fwd_data(ld_fwd_data),
    .dm_busy(dm_busy), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_be(dm_be),
    .stb_empty(stb_empty)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
    step();
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    dm_busy = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h100;
    #1;
    total_cnt++; if (st_ready !== 1'b1) $display("FAIL reset_st_ready got %b exp 1", st_ready); else pass_cnt++;
    total_cnt++; if (stb_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", stb_empty); else pass_cnt++;
    total_cnt++; if (dm_we !== 1'b0) $display("FAIL reset_dm_we got %b exp 0", dm_we); else pass_cnt++;
    total_cnt++; if ({dm_addr, dm_wd, dm_be} !== 68'h0) $display("FAIL reset_dm_bus got %h %h %h exp 0", dm_addr, dm_wd, dm_be); else pass_cnt++;
    total_cnt++; if ({ld_fwd_be, ld_fwd_data} !== 36'h0) $display("FAIL reset_fwd got %h %h exp 0", ld_fwd_be, ld_fwd_data); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_forward_basic();
    dm_busy = 1'b1;
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_be = 4'hF;
    ld_valid = 1'b1; ld_addr = 32'h100;
    #1;
    total_cnt++; if (ld_fwd_be !== 4'h0) $display("FAIL fwd_same_cycle got %h exp 0", ld_fwd_be); else pass_cnt++;
    step();
    st_valid = 1'b0;
    #1;
    total_cnt++; if (stb_empty !== 1'b0) $display("FAIL fwd_empty got %b exp 0", stb_empty); else pass_cnt++;
    total_cnt++; if (ld_fwd_be !== 4'hF) $display("FAIL fwd_be got %h exp F", ld_fwd_be); else pass_cnt++;
    total_cnt++; if (ld_fwd_data !== 32'hDEADBEEF) $display("FAIL fwd_data got %h exp DEADBEEF", ld_fwd_data); else pass_cnt++;
    total_cnt++; if (dm_we !== 1'b0) $display("FAIL fwd_busy_we got %b exp 0", dm_we); else pass_cnt++;
    ld_valid = 1'b0;
    #1;
    total_cnt++; if ({ld_fwd_be, ld_fwd_data} !== 36'h0) $display("FAIL fwd_ld_invalid got %h %h exp 0", ld_fwd_be, ld_fwd_data); else pass_cnt++;
    ld_addr = 32'h104; ld_valid = 1'b1;
    #1;
    total_cnt++; if (ld_fwd_be !== 4'h0) $display("FAIL fwd_other_word got %h exp 0", ld_fwd_be); else pass_cnt++;
    ld_valid = 1'b0;
    dm_busy = 1'b0;
    #1;
    total_cnt++; if ({dm_we, dm_addr, dm_wd, dm_be} !== {1'b1, 32'h100, 32'hDEADBEEF, 4'hF}) $display("FAIL fwd_drain got %b %h %h %h exp 1 100 DEADBEEF F", dm_we, dm_addr, dm_wd, dm_be); else pass_cnt++;
    step();
    total_cnt++; if ({stb_empty, dm_we} !== 2'b10) $display("FAIL fwd_after_drain got %b%b exp 10", stb_empty, dm_we); else pass_cnt++;
  endtask

  task automatic test_partial_merge();
    dm_busy = 1'b1;
    push(32'h200, 32'h000000AA, 4'h1);
    push(32'h200, 32'h00CC0000, 4'h4);
    ld_valid = 1'b1; ld_addr = 32'h202;
    #1;
    total_cnt++; if (ld_fwd_be !== 4'h5) $display("FAIL merge_be got %h exp 5", ld_fwd_be); else pass_cnt++;
    total_cnt++; if (ld_fwd_data !== 32'h00CC00AA) $display("FAIL merge_data got %h exp 00CC00AA", ld_fwd_data); else pass_cnt++;
    ld_valid = 1'b0;
    dm_busy = 1'b0;
    #1;
`ifdef STB_COALESCE_EN
    total_cnt++; if ({dm_we, dm_addr, dm_wd, dm_be} !== {1'b1, 32'h200, 32'h00CC00AA, 4'h5}) $display("FAIL merge_drain got %b %h %h %h exp 1 200 00CC00AA 5", dm_we, dm_addr, dm_wd, dm_be); else pass_cnt++;
    step();
`else
    total_cnt++; if ({dm_we, dm_addr, dm_wd, dm_be} !== {1'b1, 32'h200, 32'h000000AA, 4'h1}) $display("FAIL merge_drain0 got %b %h %h %h exp 1 200 000000AA 1", dm_we, dm_addr, dm_wd, dm_be); else pass_cnt++;
    step();
    total_cnt++; if ({dm_we, dm_addr, dm_wd, dm_be} !== {1'b1, 32'h200, 32'h00CC0000, 4'h4}) $display("FAIL merge_drain1 got %b %h %h %h exp 1 200 00CC0000 4", dm_we, dm_addr, dm_wd, dm_be); else pass_cnt++;
    step();
`endif
    total_cnt++; if (stb_empty !== 1'b1) $display("FAIL merge_empty got %b exp 1", stb_empty); else pass_cnt++;
  endtask

  task automatic test_full_drain();
    dm_busy = 1'b1;
    for (int k = 0; k < 4; k++) push(32'h400 + 32'(4*k), 32'h1000 + 32'(k), 4'hF);
    #1;
    total_cnt++; if (st_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", st_ready); else pass_cnt++;
    dm_busy = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if ({dm_we, dm_addr, dm_wd} !== {1'b1, 32'h400 + 32'(4*k), 32'h1000 + 32'(k)}) $display("FAIL full_drain%0d got %b %h %h", k, dm_we, dm_addr, dm_wd); else pass_cnt++;
      if (k == 0) begin
        total_cnt++; if (st_ready !== 1'b0) $display("FAIL full_ready_draining got %b exp 0", st_ready); else pass_cnt++;
      end
      step();
      if (k == 0) begin
        total_cnt++; if (st_ready !== 1'b1) $display("FAIL full_ready_after got %b exp 1", st_ready); else pass_cnt++;
      end
    end
    total_cnt++; if ({stb_empty, dm_we} !== 2'b10) $display("FAIL full_empty got %b%b exp 10", stb_empty, dm_we); else pass_cnt++;
  endtask

  task automatic test_full_push_draining();
    logic [31:0] exp_addr [4];
    logic [31:0] exp_data [4];
    exp_addr[0] = 32'h504; exp_addr[1] = 32'h508; exp_addr[2] = 32'h50C; exp_addr[3] = 32'h600;
    exp_data[0] = 32'h51;  exp_data[1] = 32'h52;  exp_data[2] = 32'h53;  exp_data[3] = 32'h66;
    dm_busy = 1'b1;
    for (int k = 0; k < 4; k++) push(32'h500 + 32'(4*k), 32'h50 + 32'(k), 4'hF);
    dm_busy = 1'b0;
    st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h66; st_be = 4'hF;
    #1;
    total_cnt++; if ({st_ready, dm_we} !== 2'b01) $display("FAIL fpd_blocked got %b%b exp 01", st_ready, dm_we); else pass_cnt++;
    step();
    dm_busy = 1'b1;
    #1;
    total_cnt++; if (st_ready !== 1'b1) $display("FAIL fpd_ready got %b exp 1", st_ready); else pass_cnt++;
    step();
    st_valid = 1'b0;
    #1;
    total_cnt++; if (st_ready !== 1'b0) $display("FAIL fpd_refull got %b exp 0", st_ready); else pass_cnt++;
    dm_busy = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if ({dm_we, dm_addr, dm_wd} !== {1'b1, exp_addr[k], exp_data[k]}) $display("FAIL fpd_drain%0d got %b %h %h exp 1 %h %h", k, dm_we, dm_addr, dm_wd, exp_addr[k], exp_data[k]); else pass_cnt++;
      step();
    end
    total_cnt++; if (stb_empty !== 1'b1) $display("FAIL fpd_empty got %b exp 1", stb_empty); else pass_cnt++;
  endtask

  task automatic test_same_word();
    dm_busy = 1'b1;
    push(32'h300, 32'hAAAAAAAA, 4'hF);
    push(32'h300, 32'h11111111, 4'hF);
    ld_valid = 1'b1; ld_addr = 32'h301;
    #1;
    total_cnt++; if ({ld_fwd_be, ld_fwd_data} !== {4'hF, 32'h11111111}) $display("FAIL same_fwd got %h %h exp F 11111111", ld_fwd_be, ld_fwd_data); else pass_cnt++;
    ld_valid = 1'b0;
    dm_busy = 1'b0;
    #1;
`ifndef STB_COALESCE_EN
    total_cnt++; if ({dm_we, dm_wd} !== {1'b1, 32'hAAAAAAAA}) $display("FAIL same_drain_old got %b %h exp 1 AAAAAAAA", dm_we, dm_wd); else pass_cnt++;
    step();
`endif
    total_cnt++; if ({dm_we, dm_wd} !== {1'b1, 32'h11111111}) $display("FAIL same_drain_new got %b %h exp 1 11111111", dm_we, dm_wd); else pass_cnt++;
    step();
    total_cnt++; if (stb_empty !== 1'b1) $display("FAIL same_empty got %b exp 1", stb_empty); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    dm_busy = 1'b1;
    push(32'h700, 32'h77, 4'hF);
    push(32'h704, 32'h78, 4'hF);
    push(32'h708, 32'h79, 4'hF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    dm_busy = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h700;
    #1;
    total_cnt++; if (stb_empty !== 1'b1) $display("FAIL rmid_empty got %b exp 1", stb_empty); else pass_cnt++;
    total_cnt++; if (dm_we !== 1'b0) $display("FAIL rmid_we got %b exp 0", dm_we); else pass_cnt++;
    total_cnt++; if (ld_fwd_be !== 4'h0) $display("FAIL rmid_fwd got %h exp 0", ld_fwd_be); else pass_cnt++;
    total_cnt++; if (st_ready !== 1'b1) $display("FAIL rmid_ready got %b exp 1", st_ready); else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    dm_busy = 1'b0;
    idle_inputs();
    test_reset();
    test_forward_basic();
    test_partial_merge();
    test_full_drain();
    test_full_push_draining();
    test_same_word();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
